// File: rtl/me_block_fetch.sv
// Read-side sequencer for the dual-port pixel memory.
// Streams BLK*BLK (template, search-window) pixel pairs for one candidate
// through a 2-entry first-word-fall-through skid FIFO that covers the
// memory's 1-cycle registered read latency under valid/ready backpressure.
module me_block_fetch #(
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 8,
    parameter int BLK     = 4,
    parameter int SW_W    = 16,
    parameter int CWIDTH  = 4,
    parameter int TB_BASE = 0,
    parameter int SW_BASE = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CWIDTH-1:0] cand_x,
    input  logic [CWIDTH-1:0] cand_y,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH-1:0] address_a,
    output logic [AWIDTH-1:0] address_b,
    output logic              wren_a,
    output logic              wren_b,
    output logic [7:0]        data_a,
    output logic [7:0]        data_b,
    input  logic [DWIDTH-1:0] q_a,
    input  logic [DWIDTH-1:0] q_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_tb,
    output logic [DWIDTH-1:0] out_sw,
    output logic              out_last
);

    localparam int XW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [CWIDTH:0] CMAX = (CWIDTH+1)'(SW_W - BLK);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                     state;
    logic [CWIDTH-1:0]          cx, cy;
    logic [XW-1:0]              bx, by;
    logic                       inflight, last_d;
    logic [AWIDTH-1:0]          addr_a_q, addr_b_q, beat_a, beat_b;
    logic [1:0][DWIDTH-1:0]     f_tb, f_sw;
    logic [1:0]                 f_last;
    logic                       wr_ptr, rd_ptr;
    logic [1:0]                 count;
    logic [2:0]                 occ;
    logic                       ok, pop, issue, last_beat;

    assign wren_a = 1'b0;
    assign wren_b = 1'b0;
    assign data_a = '0;
    assign data_b = '0;

    assign ok        = ({1'b0, cand_x} <= CMAX) && ({1'b0, cand_y} <= CMAX);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // Entries already committed after this edge: stored + arriving - leaving.
    // An issue now lands next cycle, so it needs this to leave a free slot.
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (state == FETCH) && (occ < 3'd2);
    assign last_beat = (bx == XW'(BLK-1)) && (by == XW'(BLK-1));

    assign beat_a = AWIDTH'(TB_BASE) + AWIDTH'(by) * AWIDTH'(BLK) + AWIDTH'(bx);
    assign beat_b = AWIDTH'(SW_BASE) + (AWIDTH'(cy) + AWIDTH'(by)) * AWIDTH'(SW_W)
                  + AWIDTH'(cx) + AWIDTH'(bx);

    // The address is driven in the issuing cycle so read data returns in the
    // very next cycle; otherwise the last issued address is held.
    assign address_a = issue ? beat_a : addr_a_q;
    assign address_b = issue ? beat_b : addr_b_q;

    assign out_tb   = f_tb[rd_ptr];
    assign out_sw   = f_sw[rd_ptr];
    assign out_last = f_last[rd_ptr];

    // Control FSM: accept/validate start, walk the beats, wait for the drain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (ok) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                        cx    <= cand_x;
                        cy    <= cand_y;
                    end else begin
                        err <= 1'b1;
                    end
                end
                FETCH: if (issue && last_beat) state <= DRAIN;
                DRAIN: if (pop && out_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Raster beat counters, advanced once per issued address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bx <= '0;
            by <= '0;
        end else if (state == IDLE) begin
            bx <= '0;
            by <= '0;
        end else if (issue) begin
            if (bx == XW'(BLK-1)) begin
                bx <= '0;
                by <= by + XW'(1);
            end else begin
                bx <= bx + XW'(1);
            end
        end
    end

    // Track the outstanding read and hold the last issued addresses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            last_d   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            inflight <= issue;
            last_d   <= issue && last_beat;
            if (issue) begin
                addr_a_q <= beat_a;
                addr_b_q <= beat_b;
            end
        end
    end

    // Skid FIFO: returning read data is pushed, downstream handshakes pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_tb   <= '0;
            f_sw   <= '0;
            f_last <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (inflight) begin
                f_tb[wr_ptr]   <= q_a;
                f_sw[wr_ptr]   <= q_b;
                f_last[wr_ptr] <= last_d;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_me_block_fetch.sv
// Randomized self-checking bench for me_block_fetch with a registered-read
// memory model and a beat-by-beat reference computed from the block geometry.
module tb_me_block_fetch;

    logic       clock = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [3:0] cand_x = '0, cand_y = '0;
    logic       busy, done, err, wren_a, wren_b, out_valid, out_last;
    logic [9:0] address_a, address_b;
    logic [7:0] data_a, data_b, q_a, q_b, out_tb, out_sw;
    logic [7:0] mem [0:1023];
    int         vectors = 0, miscompares = 0;

    me_block_fetch dut (
        .clock(clock), .reset(reset), .start(start), .cand_x(cand_x), .cand_y(cand_y),
        .busy(busy), .done(done), .err(err), .address_a(address_a), .address_b(address_b),
        .wren_a(wren_a), .wren_b(wren_b), .data_a(data_a), .data_b(data_b),
        .q_a(q_a), .q_b(q_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_tb(out_tb), .out_sw(out_sw), .out_last(out_last)
    );

    always #5 clock = ~clock;

    // Memory with 1-cycle registered read.
    always @(posedge clock) begin
        q_a <= mem[address_a];
        q_b <= mem[address_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference geometry: beat k is pixel (k%4, k/4) of the 4x4 block.
    function automatic int ref_a(input int k);
        return (0 + (k / 4) * 4 + (k % 4)) % 1024;
    endfunction
    function automatic int ref_b(input int cx, input int cy, input int k);
        return (256 + (cy + k / 4) * 16 + cx + (k % 4)) % 1024;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_addr_a"}, address_a, 0);
        chk({tag, "_addr_b"}, address_b, 0);
        chk({tag, "_tb"}, out_tb, 0);
        chk({tag, "_sw"}, out_sw, 0);
    endtask

    // mode 0: ready always 1 (timing + address checks); 1: 5-cycle stall at
    // beat 6 then random; 2: random ready plus an ignored start mid-run.
    // abort_at >= 0 returns right after that beat's handshake is committed.
    task automatic run_cand(input int cx, input int cy, input int mode, input int abort_at);
        int k = 0, first = -1, stall = 0;
        logic pv = 1'b0, pl = 1'b0;
        logic [7:0] ptb = '0, psw = '0;
        @(negedge clock);
        cand_x = 4'(cx); cand_y = 4'(cy); start = 1'b1; out_ready = 1'b1;
        for (int n = 1; n < 300; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            if (mode == 2 && n == 5) begin start = 1'b1; cand_x = 4'($urandom_range(0, 12)); end
            if (mode == 2 && n == 6) start = 1'b0;
            if (n == 1) chk("busy_after_start", busy, 1);
            if (mode == 0 && n <= 16) begin
                chk("addr_a", address_a, ref_a(n - 1));
                chk("addr_b", address_b, ref_b(cx, cy, n - 1));
            end
            chk("err_quiet", err, 0);
            if (pv) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_tb", out_tb, ptb);
                chk("stall_sw", out_sw, psw);
                chk("stall_last", out_last, pl);
            end
            if (out_valid && first < 0) begin
                first = n;
                chk("first_valid_cycle", first, 3);
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1 && k < 6) out_ready = 1'b1;
            else if (mode == 1 && k == 6 && stall < 5) begin out_ready = 1'b0; stall++; end
            else out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                chk("beat_tb", out_tb, mem[ref_a(k)]);
                chk("beat_sw", out_sw, mem[ref_b(cx, cy, k)]);
                chk("beat_last", out_last, (k == 15) ? 1 : 0);
                if (mode == 0) chk("beat_cycle", n, 3 + k);
                k++;
                if (k == abort_at + 1) return;
                if (k == 16) begin
                    @(negedge clock);
                    out_ready = 1'b0;
                    chk("done_pulse", done, 1);
                    @(negedge clock);
                    chk("done_clear", done, 0);
                    chk("busy_clear", busy, 0);
                    chk("no_extra_valid", out_valid, 0);
                    return;
                end
            end
            pv = out_valid && !out_ready;
            ptb = out_tb; psw = out_sw; pl = out_last;
        end
        chk("stream_timeout_beats", k, 16);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        #2 reset = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge clock); reset = 1'b0;

        // Identity memory, cand (0,0): closed-form pixel values too.
        run_cand(0, 0, 0, -1);
        chk("ident_sw_beat5", mem[ref_b(0, 0, 5)], (256 + 16 + 1) & 8'hFF);

        // Corner candidate: addresses 460 .. 511.
        run_cand(12, 12, 0, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        // Stall at beat 6 then random backpressure.
        run_cand(5, 9, 1, -1);

        // Out-of-range candidates.
        for (int t = 0; t < 4; t++) begin
            logic [9:0] pa, pb;
            @(negedge clock);
            pa = address_a; pb = address_b;
            if (t == 0) begin cand_x = 4'd13; cand_y = 4'd0; end
            else if (t[0]) begin cand_x = 4'($urandom_range(0, 15)); cand_y = 4'($urandom_range(13, 15)); end
            else begin cand_x = 4'($urandom_range(13, 15)); cand_y = 4'($urandom_range(0, 15)); end
            start = 1'b1;
            @(negedge clock); start = 1'b0;
            chk("bad_err", err, 1);
            chk("bad_busy", busy, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                chk("bad_err_clear", err, 0);
                chk("bad_no_valid", out_valid, 0);
                chk("bad_addr_a", address_a, pa);
                chk("bad_addr_b", address_b, pb);
            end
        end

        // Random candidates with random backpressure.
        for (int t = 0; t < 6; t++)
            run_cand($urandom_range(0, 12), $urandom_range(0, 12), 2, -1);

        // Reset after beat 7 is accepted, then a clean restart.
        run_cand(0, 0, 0, 7);
        @(posedge clock); #1 reset = 1'b1;
        #1 chk_reset_vals("midreset");
        @(negedge clock); reset = 1'b0; out_ready = 1'b0;
        run_cand(0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
